slc3_input_conditioner: RTL and testbench



---
 rtl/slc3_io_pkg.sv | 22 ++
 rtl/slc3_input_conditioner_if.sv | 29 ++
 rtl/key_debouncer.sv | 84 ++++++++
 rtl/slc3_input_conditioner.sv | 114 +++++++++++
 tb/tb_slc3_input_conditioner.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/slc3_io_pkg.sv
// Shared types and defaults for the SLC-3 board input conditioner.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package slc3_io_pkg;

    typedef enum logic [1:0] {
        RELEASED,
        PRESS_WAIT,
        PRESSED,
        RELEASE_WAIT
    } key_state_t;

    localparam logic [15:0] DEBOUNCE_CYCLES_DEF = 16'd50000;
    localparam logic [15:0] COMBO_CYCLES_DEF    = 16'd25000;
    localparam int          SW_WIDTH_DEF        = 10;

    // Counters hold at all-ones rather than wrapping back to zero.
    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/slc3_input_conditioner_if.sv
// Pin-side raw inputs and conditioned outputs of the SLC-3 input stage.
// Latency: n/a (wiring only).
// Backpressure: none; all signals are free-running levels or pulses.
interface slc3_input_conditioner_if
    import slc3_io_pkg::*;
#(
    parameter int SW_WIDTH = SW_WIDTH_DEF
);
    logic                Run_raw;
    logic                Continue_raw;
    logic [SW_WIDTH-1:0] SW_raw;
    logic                Run;
    logic                Continue;
    logic                run_pulse;
    logic                continue_pulse;
    logic [SW_WIDTH-1:0] SW;
    logic                sw_changed;
    logic                combo_reset;

    modport master (
        output Run_raw, Continue_raw, SW_raw,
        input  Run, Continue, run_pulse, continue_pulse, SW, sw_changed, combo_reset
    );

    modport slave (
        input  Run_raw, Continue_raw, SW_raw,
        output Run, Continue, run_pulse, continue_pulse, SW, sw_changed, combo_reset
    );
endinterface

// File: rtl/key_debouncer.sv
// Two-flop synchronizer plus debounce FSM for one active-low key.
// Latency: 2 + DEBOUNCE_CYCLES clock edges from a stable raw edge to level.
// Backpressure: none; suppress only masks the press pulse.
module key_debouncer
    import slc3_io_pkg::*;
#(
    parameter logic [15:0] DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
)(
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    input  logic suppress,
    output logic level,
    output logic press_pulse
);
    logic        sync_q1;
    logic        sync_q2;
    key_state_t  state;
    logic [15:0] cnt;
    logic [15:0] cnt_inc;
    logic        terminal;

    assign cnt_inc  = sat_inc(cnt);
    // The entry cycle already counts as the first stable sample.
    assign terminal = (cnt_inc == DEBOUNCE_CYCLES - 16'd1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q1 <= 1'b1;
            sync_q2 <= 1'b1;
        end else begin
            sync_q1 <= raw;
            sync_q2 <= sync_q1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= RELEASED;
            cnt         <= 16'd0;
            level       <= 1'b1;
            press_pulse <= 1'b0;
        end else begin
            press_pulse <= 1'b0;
            case (state)
                RELEASED: begin
                    if (!sync_q2) begin
                        state <= PRESS_WAIT;
                        cnt   <= 16'd0;
                    end
                end
                PRESS_WAIT: begin
                    if (sync_q2) begin
                        state <= RELEASED;
                    end else if (terminal) begin
                        state       <= PRESSED;
                        level       <= 1'b0;
                        press_pulse <= ~suppress;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                PRESSED: begin
                    if (sync_q2) begin
                        state <= RELEASE_WAIT;
                        cnt   <= 16'd0;
                    end
                end
                RELEASE_WAIT: begin
                    if (!sync_q2) begin
                        state <= PRESSED;
                    end else if (terminal) begin
                        state <= RELEASED;
                        level <= 1'b1;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                default: state <= RELEASED;
            endcase
        end
    end

endmodule

// File: rtl/slc3_input_conditioner.sv
// Synchronizes/debounces Run, Continue and switches; makes press pulses and combo reset.
// Latency: 2 + DEBOUNCE_CYCLES edges for keys and switches; combo_reset 1 edge to drop.
// Backpressure: none; outputs are levels and single-cycle pulses.
module slc3_input_conditioner
    import slc3_io_pkg::*;
#(
    parameter logic [15:0] DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter logic [15:0] COMBO_CYCLES    = COMBO_CYCLES_DEF,
    parameter int          SW_WIDTH        = SW_WIDTH_DEF
)(
    input  logic                    Clk,
    input  logic                    Reset_n,
    slc3_input_conditioner_if.slave io
);
    logic                run_lvl;
    logic                cont_lvl;
    logic                run_pls;
    logic                cont_pls;
    logic                combo_q;
    logic                combo_hold;
    logic [15:0]         combo_cnt;
    logic                both_low;
    logic [SW_WIDTH-1:0] sw_q1;
    logic [SW_WIDTH-1:0] sw_q2;
    logic [SW_WIDTH-1:0] sw_prev;
    logic [SW_WIDTH-1:0] sw_q;
    logic                sw_chg_q;
    logic [15:0]         sw_cnt;
    logic [15:0]         sw_cnt_inc;

    key_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_run_key (
        .clk         (Clk),
        .rst_n       (Reset_n),
        .raw         (io.Run_raw),
        .suppress    (combo_hold),
        .level       (run_lvl),
        .press_pulse (run_pls)
    );

    key_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_cont_key (
        .clk         (Clk),
        .rst_n       (Reset_n),
        .raw         (io.Continue_raw),
        .suppress    (combo_hold),
        .level       (cont_lvl),
        .press_pulse (cont_pls)
    );

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            sw_q1 <= '0;
            sw_q2 <= '0;
        end else begin
            sw_q1 <= io.SW_raw;
            sw_q2 <= sw_q1;
        end
    end

    assign sw_cnt_inc = sat_inc(sw_cnt);

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            sw_prev  <= '0;
            sw_cnt   <= 16'd0;
            sw_q     <= '0;
            sw_chg_q <= 1'b0;
        end else begin
            sw_prev  <= sw_q2;
            sw_chg_q <= 1'b0;
            if (sw_q2 != sw_prev) begin
                sw_cnt <= 16'd0;
            end else begin
                sw_cnt <= sw_cnt_inc;
                // A bus that settled back on the current value commits nothing.
                if ((sw_cnt_inc == DEBOUNCE_CYCLES - 16'd1) && (sw_q2 != sw_q)) begin
                    sw_q     <= sw_q2;
                    sw_chg_q <= 1'b1;
                end
            end
        end
    end

    assign both_low = ~run_lvl & ~cont_lvl;

    // combo_hold outlives combo_reset until both keys are up, muting re-presses.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            combo_cnt  <= 16'd0;
            combo_q    <= 1'b0;
            combo_hold <= 1'b0;
        end else if (both_low) begin
            combo_cnt <= sat_inc(combo_cnt);
            if (combo_cnt == COMBO_CYCLES - 16'd1) begin
                combo_q    <= 1'b1;
                combo_hold <= 1'b1;
            end
        end else begin
            combo_cnt <= 16'd0;
            combo_q   <= 1'b0;
            if (run_lvl && cont_lvl) begin
                combo_hold <= 1'b0;
            end
        end
    end

    assign io.Run            = run_lvl;
    assign io.Continue       = cont_lvl;
    assign io.run_pulse      = run_pls;
    assign io.continue_pulse = cont_pls;
    assign io.SW             = sw_q;
    assign io.sw_changed     = sw_chg_q;
    assign io.combo_reset    = combo_q;

endmodule

// File: tb/tb_slc3_input_conditioner.sv
// Bench for slc3_input_conditioner: directed vector table plus randomized run-length model.
`timescale 1ns/1ps
module tb_slc3_input_conditioner;
    import slc3_io_pkg::*;

    localparam logic [15:0] DEB   = 16'd4;
    localparam logic [15:0] CMB   = 16'd3;
    localparam int          DEB_I = 4;
    localparam int          CMB_I = 3;
    localparam int          SWW   = 10;

    logic Clk = 1'b0;
    logic Reset_n;

    slc3_input_conditioner_if #(.SW_WIDTH(SWW)) io ();

    slc3_input_conditioner #(
        .DEBOUNCE_CYCLES (DEB),
        .COMBO_CYCLES    (CMB),
        .SW_WIDTH        (SWW)
    ) dut (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .io      (io.slave)
    );

    always #5 Clk = ~Clk;

    int checks   = 0;
    int failures = 0;

    // Reference model: a level flips once the synchronized input has disagreed with it
    // for DEB consecutive cycles; switches commit after DEB cycles of an unchanged bus.
    logic            m_rs1, m_rs2, m_cs1, m_cs2;
    logic [SWW-1:0]  m_ss1, m_ss2, m_sprev, m_sw;
    logic            m_run, m_cont, m_rp, m_cp, m_combo, m_hold, m_swc;
    int              m_rrun, m_crun, m_stable, m_both;

    task automatic model_reset();
        m_rs1 = 1'b1; m_rs2 = 1'b1; m_cs1 = 1'b1; m_cs2 = 1'b1;
        m_ss1 = '0; m_ss2 = '0; m_sprev = '0; m_sw = '0;
        m_run = 1'b1; m_cont = 1'b1; m_rp = 1'b0; m_cp = 1'b0;
        m_combo = 1'b0; m_hold = 1'b0; m_swc = 1'b0;
        m_rrun = 0; m_crun = 0; m_stable = 0; m_both = 0;
    endtask

    task automatic model_edge(input logic rr, input logic cr, input logic [SWW-1:0] swr);
        logic run_old, cont_old;
        run_old  = m_run;
        cont_old = m_cont;
        if (!run_old && !cont_old) m_both++; else m_both = 0;
        m_combo = (m_both >= CMB_I);
        m_rp = 1'b0;
        m_cp = 1'b0;
        if (m_rs2 != m_run) m_rrun++; else m_rrun = 0;
        if (m_rrun == DEB_I) begin
            m_run = m_rs2; m_rrun = 0; m_rp = !m_rs2 && !m_hold;
        end
        if (m_cs2 != m_cont) m_crun++; else m_crun = 0;
        if (m_crun == DEB_I) begin
            m_cont = m_cs2; m_crun = 0; m_cp = !m_cs2 && !m_hold;
        end
        if (m_combo) m_hold = 1'b1;
        else if (run_old && cont_old) m_hold = 1'b0;
        if (m_ss2 == m_sprev) m_stable++; else m_stable = 1;
        m_sprev = m_ss2;
        m_swc = 1'b0;
        if (m_stable >= DEB_I && m_ss2 != m_sw) begin
            m_sw = m_ss2; m_swc = 1'b1;
        end
        m_rs2 = m_rs1; m_rs1 = rr;
        m_cs2 = m_cs1; m_cs1 = cr;
        m_ss2 = m_ss1; m_ss1 = swr;
    endtask

    always @(negedge Reset_n) model_reset();
    always @(posedge Clk) if (Reset_n) model_edge(io.Run_raw, io.Continue_raw, io.SW_raw);

    function automatic logic [15:0] ev(input logic run, input logic cont, input logic rp,
                                       input logic cp, input logic cmb, input logic swc,
                                       input logic [SWW-1:0] sw);
        return {run, cont, rp, cp, cmb, swc, sw};
    endfunction

    function automatic logic [15:0] dut_vec();
        return {io.Run, io.Continue, io.run_pulse, io.continue_pulse,
                io.combo_reset, io.sw_changed, io.SW};
    endfunction

    function automatic logic [15:0] model_vec();
        return {m_run, m_cont, m_rp, m_cp, m_combo, m_swc, m_sw};
    endfunction

    // Vector layout: {Run, Continue, run_pulse, continue_pulse, combo_reset, sw_changed, SW}
    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic step(input logic rr, input logic cr, input logic [SWW-1:0] swr, input string name);
        @(negedge Clk);
        io.Run_raw      = rr;
        io.Continue_raw = cr;
        io.SW_raw       = swr;
        @(posedge Clk);
        #1;
        check({"model_", name}, dut_vec(), model_vec());
    endtask

    typedef struct {
        logic           rr;
        logic           cr;
        logic [SWW-1:0] sw;
        int             n;
        logic [15:0]    exp;
        string          name;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic rr, input logic cr, input logic [SWW-1:0] sw, input int n,
                       input logic [15:0] exp, input string name);
        vec_t v;
        v.rr = rr; v.cr = cr; v.sw = sw; v.n = n; v.exp = exp; v.name = name;
        tbl.push_back(v);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached, checks=%0d", checks);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic           rr_v, cr_v;
        logic [SWW-1:0] sw_v;
        int             rr_left, cr_left, sw_left;

        add(0, 1, 10'h000, 5, ev(1,1,0,0,0,0,10'h000), "run_press_wait");
        add(0, 1, 10'h000, 1, ev(0,1,1,0,0,0,10'h000), "run_press_commit");
        add(0, 1, 10'h000, 1, ev(0,1,0,0,0,0,10'h000), "run_pulse_single");
        add(1, 1, 10'h000, 5, ev(0,1,0,0,0,0,10'h000), "run_release_wait");
        add(1, 1, 10'h000, 1, ev(1,1,0,0,0,0,10'h000), "run_release_commit");
        for (int g = 0; g < 5; g++) begin
            add(1, 0, 10'h000, 3, ev(1,1,0,0,0,0,10'h000), "cont_glitch_low");
            add(1, 1, 10'h000, 3, ev(1,1,0,0,0,0,10'h000), "cont_glitch_high");
        end
        add(1, 1, 10'h000, 4, ev(1,1,0,0,0,0,10'h000), "cont_glitch_settle");
        add(1, 1, 10'h05A, 5, ev(1,1,0,0,0,0,10'h000), "sw_wait");
        add(1, 1, 10'h05A, 1, ev(1,1,0,0,0,1,10'h05A), "sw_commit");
        add(1, 1, 10'h05A, 1, ev(1,1,0,0,0,0,10'h05A), "sw_pulse_single");
        for (int g = 0; g < 3; g++) begin
            add(1, 1, 10'h05B, 2, ev(1,1,0,0,0,0,10'h05A), "sw_toggle_hi");
            add(1, 1, 10'h05A, 2, ev(1,1,0,0,0,0,10'h05A), "sw_toggle_lo");
        end
        add(1, 1, 10'h05A, 6, ev(1,1,0,0,0,0,10'h05A), "sw_return_no_pulse");
        add(0, 0, 10'h05A, 5, ev(1,1,0,0,0,0,10'h05A), "both_wait");
        add(0, 0, 10'h05A, 1, ev(0,0,1,1,0,0,10'h05A), "both_pulses");
        add(0, 0, 10'h05A, 1, ev(0,0,0,0,0,0,10'h05A), "combo_count1");
        add(0, 0, 10'h05A, 1, ev(0,0,0,0,0,0,10'h05A), "combo_count2");
        add(0, 0, 10'h05A, 1, ev(0,0,0,0,1,0,10'h05A), "combo_assert");
        add(0, 0, 10'h05A, 3, ev(0,0,0,0,1,0,10'h05A), "combo_stays");
        add(1, 0, 10'h05A, 5, ev(0,0,0,0,1,0,10'h05A), "run_rel_wait");
        add(1, 0, 10'h05A, 1, ev(1,0,0,0,1,0,10'h05A), "run_rel_level");
        add(1, 0, 10'h05A, 1, ev(1,0,0,0,0,0,10'h05A), "combo_deassert");
        add(0, 0, 10'h05A, 6, ev(0,0,0,0,0,0,10'h05A), "repress_suppressed");
        add(0, 0, 10'h05A, 3, ev(0,0,0,0,1,0,10'h05A), "combo_again");
        add(1, 1, 10'h05A, 6, ev(1,1,0,0,1,0,10'h05A), "both_rel_levels");
        add(1, 1, 10'h05A, 1, ev(1,1,0,0,0,0,10'h05A), "both_rel_combo_off");
        add(0, 1, 10'h05A, 6, ev(0,1,1,0,0,0,10'h05A), "run_alone_pulse");
        add(0, 0, 10'h05A, 6, ev(0,0,0,1,0,0,10'h05A), "cont_while_run_pulse");
        add(0, 1, 10'h05A, 6, ev(0,1,0,0,1,0,10'h05A), "cont_release");
        add(0, 1, 10'h05A, 1, ev(0,1,0,0,0,0,10'h05A), "cont_release_combo_off");
        add(0, 0, 10'h05A, 6, ev(0,0,0,0,0,0,10'h05A), "cont_repress_suppressed");
        add(1, 1, 10'h05A, 7, ev(1,1,0,0,0,0,10'h05A), "final_release");

        // Reset held with Run pressed and all switches up.
        io.Run_raw      = 1'b0;
        io.Continue_raw = 1'b1;
        io.SW_raw       = 10'h3FF;
        Reset_n         = 1'b1;
        #2 Reset_n = 1'b0;
        #1 check("reset_async_assert", dut_vec(), ev(1,1,0,0,0,0,10'h000));
        for (int k = 0; k < 3; k++) begin
            step(0, 1, 10'h3FF, "rst_held");
            check("rst_held_outputs", dut_vec(), ev(1,1,0,0,0,0,10'h000));
        end
        Reset_n = 1'b1;
        step(0, 1, 10'h3FF, "rel_edge1");
        check("first_edge_after_release", dut_vec(), ev(1,1,0,0,0,0,10'h000));
        for (int k = 0; k < 3; k++) step(0, 1, 10'h3FF, "rel_count");
        Reset_n = 1'b0;
        #1 check("reset_mid_press_wait", dut_vec(), ev(1,1,0,0,0,0,10'h000));
        step(0, 1, 10'h3FF, "rst_mid_held");
        Reset_n = 1'b1;
        for (int k = 0; k < 5; k++) step(0, 1, 10'h3FF, "rel2_count");
        check("no_early_commit", dut_vec(), ev(1,1,0,0,0,0,10'h000));
        step(0, 1, 10'h3FF, "rel2_commit");
        check("commit_after_reset", dut_vec(), ev(0,1,1,0,0,1,10'h3FF));

        Reset_n = 1'b0;
        step(1, 1, 10'h000, "idle_rst");
        Reset_n = 1'b1;
        for (int k = 0; k < 3; k++) step(1, 1, 10'h000, "idle");
        check("idle_after_reset", dut_vec(), ev(1,1,0,0,0,0,10'h000));

        for (int i = 0; i < tbl.size(); i++) begin
            for (int k = 0; k < tbl[i].n; k++) step(tbl[i].rr, tbl[i].cr, tbl[i].sw, tbl[i].name);
            check(tbl[i].name, dut_vec(), tbl[i].exp);
        end

        rr_v = 1'b1; cr_v = 1'b1; sw_v = 10'h05A;
        rr_left = 0; cr_left = 0; sw_left = 0;
        for (int c = 0; c < 3000; c++) begin
            if (rr_left == 0) begin
                rr_v = 1'($urandom_range(0, 1));
                rr_left = $urandom_range(1, 12);
            end
            if (cr_left == 0) begin
                cr_v = 1'($urandom_range(0, 1));
                cr_left = $urandom_range(1, 12);
            end
            if (sw_left == 0) begin
                if ($urandom_range(0, 3) == 0) sw_v = 10'($urandom_range(0, 1023));
                else sw_v = sw_v ^ (10'd1 << $urandom_range(0, 9));
                sw_left = $urandom_range(1, 8);
            end
            if (c == 1500) Reset_n = 1'b0;
            if (c == 1502) Reset_n = 1'b1;
            step(rr_v, cr_v, sw_v, "random");
            rr_left--;
            cr_left--;
            sw_left--;
        end

        for (int k = 0; k < 20; k++) step(1, 1, sw_v, "drain");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
